// File: rtl/coin_return_dispenser.sv
// Coin return dispenser: latches the customer balance (50-won units) on a
// return request and pays it out one coin at a time. It pulses the 100-won
// solenoid while at least 100 won remains and the 100-won hopper is not
// empty, and the 50-won solenoid otherwise. Reports busy/done to the controller.
module coin_return_dispenser #(
    parameter int BAL_W     = 4,
    parameter int PULSE_CYC = 4,
    parameter int GAP_CYC   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             coin_ret,
    input  logic [BAL_W-1:0] balance,
    input  logic             empty_100,
    output logic             ret_100,
    output logic             ret_50,
    output logic             busy,
    output logic             done,
    output logic [BAL_W-1:0] ret_total
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECIDE = 3'd1,
        S_PULSE  = 3'd2,
        S_GAP    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // A single counter times both the pulse phase and the gap phase.
    localparam int CNT_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);

    state_t           state_q, state_d;
    logic [BAL_W-1:0] remaining_q, remaining_d;
    logic [BAL_W-1:0] total_q, total_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sel_100_q, sel_100_d;
    logic [BAL_W-1:0] step;

    logic ret_100_q, ret_100_d;
    logic ret_50_q, ret_50_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    // Coin value in 50-won units for the coin currently being paid out.
    assign step = sel_100_q ? BAL_W'(2) : BAL_W'(1);

    // Next-state logic: sequencing, remaining balance and dispensed total.
    always_comb begin
        // NOTE: every variable gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        remaining_d = remaining_q;
        total_d     = total_q;
        cnt_d       = cnt_q;
        sel_100_d   = sel_100_q;
        case (state_q)
            S_IDLE: begin
                if (coin_ret) begin
                    remaining_d = balance;
                    total_d     = '0;
                    state_d     = (balance != '0) ? S_DECIDE : S_DONE;
                end
            end
            S_DECIDE: begin
                // The hopper sensor only matters at the moment a coin is chosen.
                sel_100_d = (remaining_q >= BAL_W'(2)) && !empty_100;
                cnt_d     = '0;
                state_d   = S_PULSE;
            end
            S_PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    cnt_d       = '0;
                    remaining_d = remaining_q - step;
                    total_d     = total_q + step;
                    state_d     = S_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = (remaining_q == '0) ? S_DONE : S_DECIDE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the current state. The outputs are registered, so
    // they lag the state by one cycle. Busy is also raised on the accepting edge.
    always_comb begin
        ret_100_d = (state_q == S_PULSE) && sel_100_q;
        ret_50_d  = (state_q == S_PULSE) && !sel_100_q;
        done_d    = (state_q == S_DONE);
        busy_d    = (state_q != S_IDLE) || coin_ret;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q     <= S_IDLE;
            remaining_q <= '0;
            total_q     <= '0;
            cnt_q       <= '0;
            sel_100_q   <= 1'b0;
            ret_100_q   <= 1'b0;
            ret_50_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            total_q     <= total_d;
            cnt_q       <= cnt_d;
            sel_100_q   <= sel_100_d;
            ret_100_q   <= ret_100_d;
            ret_50_q    <= ret_50_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign ret_100   = ret_100_q;
    assign ret_50    = ret_50_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign ret_total = total_q;

endmodule

// File: tb/tb_coin_return_dispenser.sv
// Directed testbench for coin_return_dispenser at default parameters.
// Inputs change 1 ns after each rising edge and outputs are sampled there.
// "After edge N+j" means the sample taken j edges after the accepting edge N.
module tb_coin_return_dispenser;

    logic       clk;
    logic       reset;
    logic       coin_ret;
    logic [3:0] balance;
    logic       empty_100;
    logic       ret_100;
    logic       ret_50;
    logic       busy;
    logic       done;
    logic [3:0] ret_total;

    int n_cmp;
    int n_bad;

    coin_return_dispenser dut (
        .clk       (clk),
        .reset     (reset),
        .coin_ret  (coin_ret),
        .balance   (balance),
        .empty_100 (empty_100),
        .ret_100   (ret_100),
        .ret_50    (ret_50),
        .busy      (busy),
        .done      (done),
        .ret_total (ret_total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected {ret_100, ret_50, busy, done} after edge N+j for a sequence
    // of k coins. Bit i of mask is 1 when coin i is a 100-won coin.
    // Each coin takes 7 cycles; its solenoid is high after edges 2+7i .. 5+7i.
    function automatic logic [3:0] exp_vec(input int j, input int k, input int mask);
        logic r100, r50, b, d;
        r100 = 1'b0;
        r50  = 1'b0;
        b    = (j <= 1 + 7 * k);
        d    = (j == 1 + 7 * k);
        for (int i = 0; i < k; i++) begin
            if (j >= 2 + 7 * i && j <= 5 + 7 * i) begin
                if (((mask >> i) & 1) == 1) r100 = 1'b1;
                else                        r50  = 1'b1;
            end
        end
        return {r100, r50, b, d};
    endfunction

    // Raise coin_ret for one edge with the given balance. Returns at the sample after edge N.
    task automatic start(input logic [3:0] bal);
        balance  = bal;
        coin_ret = 1'b1;
        tick();
        coin_ret = 1'b0;
    endtask

    // Check every cycle of a sequence that was just accepted.
    // At sample j == poke_a or poke_b, coin_ret is raised (with balance 9)
    // so that the following edge sees a request while the unit is busy.
    task automatic run_seq(input string name, input int k, input int mask,
                           input int exp_total, input int poke_a, input int poke_b);
        logic [3:0] got, exp;
        int last;
        last = 1 + 7 * k + 2;
        for (int j = 0; j <= last; j++) begin
            got = {ret_100, ret_50, busy, done};
            exp = exp_vec(j, k, mask);
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL %s outputs j=%0d: got r100/r50/busy/done=%b expected %b", name, j, got, exp);
            end
            n_cmp++;
            if ((ret_100 & ret_50) !== 1'b0) begin
                n_bad++;
                $display("FAIL %s overlap j=%0d: ret_100=%b ret_50=%b expected not both high", name, j, ret_100, ret_50);
            end
            if (j == 0) begin
                n_cmp++;
                if (ret_total !== 4'd0) begin
                    n_bad++;
                    $display("FAIL %s total_clear: got %0d expected 0", name, ret_total);
                end
            end
            if (j == 1 + 7 * k) begin
                n_cmp++;
                if (ret_total !== 4'(exp_total)) begin
                    n_bad++;
                    $display("FAIL %s total_at_done: got %0d expected %0d", name, ret_total, exp_total);
                end
            end
            if (j == poke_a || j == poke_b) begin
                coin_ret = 1'b1;
                balance  = 4'd9;
            end else begin
                coin_ret = 1'b0;
            end
            tick();
        end
        coin_ret = 1'b0;
    endtask

    // Check that the unit stays quiet for n cycles.
    task automatic expect_idle(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            n_cmp++;
            if ({ret_100, ret_50, busy, done} !== 4'b0000) begin
                n_bad++;
                $display("FAIL %s idle cycle %0d: got r100/r50/busy/done=%b expected 0000",
                         name, i, {ret_100, ret_50, busy, done});
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        coin_ret  = 1'b0;
        balance   = 4'd0;
        empty_100 = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({ret_100, ret_50, busy, done, ret_total} !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_state: got r100/r50/busy/done/total=%b expected 00000000",
                     {ret_100, ret_50, busy, done, ret_total});
        end
        reset = 1'b0;
        tick();
        expect_idle("after_reset", 2);
    endtask

    // balance 3: one 100-won coin, then one 50-won coin, done after N+15.
    task automatic test_mixed();
        empty_100 = 1'b0;
        start(4'd3);
        run_seq("mixed_3", 2, 'b01, 3, -1, -1);
    endtask

    // balance 0: straight to DONE, done after N+1, no solenoid activity.
    task automatic test_zero();
        empty_100 = 1'b0;
        start(4'd0);
        run_seq("zero", 0, 0, 0, -1, -1);
    endtask

    // balance 4 with an empty 100-won hopper: four 50-won coins, done after N+29.
    task automatic test_empty_hopper();
        empty_100 = 1'b1;
        start(4'd4);
        run_seq("empty_100", 4, 0, 4, -1, -1);
        empty_100 = 1'b0;
    endtask

    // balance 15: seven 100-won coins then one 50-won coin, done after N+57.
    task automatic test_max();
        empty_100 = 1'b0;
        start(4'd15);
        run_seq("max_15", 8, 'h7F, 15, -1, -1);
    endtask

    // balance 2: coin_ret (balance 9) arrives mid-pulse and again in DONE.
    // Both are ignored; one 100-won coin, done after N+8, then quiet.
    task automatic test_back_to_back();
        empty_100 = 1'b0;
        start(4'd2);
        run_seq("busy_ignore", 1, 'b1, 2, 3, 7);
        expect_idle("no_requeue", 4);
    endtask

    // balance 5: reset during the second 100-won pulse, then balance 1.
    task automatic test_reset_mid();
        logic [3:0] got, exp;
        empty_100 = 1'b0;
        start(4'd5);
        for (int j = 0; j <= 10; j++) begin
            got = {ret_100, ret_50, busy, done};
            exp = exp_vec(j, 3, 'b011);
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL reset_mid pre j=%0d: got r100/r50/busy/done=%b expected %b", j, got, exp);
            end
            if (j < 10) tick();
        end
        reset = 1'b1;
        tick();
        n_cmp++;
        if ({ret_100, ret_50, busy, done, ret_total} !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_mid outputs: got r100/r50/busy/done/total=%b expected 00000000",
                     {ret_100, ret_50, busy, done, ret_total});
        end
        reset = 1'b0;
        tick();
        expect_idle("reset_mid_idle", 3);
        start(4'd1);
        run_seq("after_reset_1", 1, 0, 1, -1, -1);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_mixed();
        test_zero();
        test_empty_hopper();
        test_max();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
